timer_controller: RTL and testbench
===================================

TIMER_CONTROLLER -- requirements
Module: timer_controller

Interface
REQ-001 Parameter ALARM_SECS, default 10: number of tick_1hz pulses the ALARM state lasts; legal range 1..63.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 tick_1hz  input  1  one-clk-wide pulse once per second.
REQ-005 btn_start  input  1  level; its rising edge requests start/resume.
REQ-006 btn_stop  input  1  level; its rising edge requests pause.
REQ-007 btn_clear  input  1  level; its rising edge requests clear.
REQ-008 btn_mode  input  1  level; its rising edge toggles the count direction.
REQ-009 target_min  input  6  count-up stop minute, 0..59; 0 means no target.
REQ-010 cnt_seconds  input  6  seconds value fed back from the minutes counter.
REQ-011 cnt_minutes  input  6  minutes value fed back from the minutes counter.
REQ-012 cnt_finish  input  1  counter terminal-value flag in the current direction.
REQ-013 cnt_enable  output  1  counter enable.
REQ-014 cnt_forward  output  1  counter direction: 1 = up, 0 = down.
REQ-015 cnt_reset  output  1  one-clk synchronous clear pulse to the counter.
REQ-016 alarm  output  1  high while in ALARM.
REQ-017 blink  output  1  display blink; toggles on each tick_1hz in ALARM and PAUSE.
REQ-018 state  output  2  current FSM state code.

Function
REQ-019 Button edges are detected internally: edge = btn & ~btn_prev; btn_prev is registered every clk.
REQ-020 FSM states: IDLE=0, RUN=1, PAUSE=2, ALARM=3.
REQ-021 All outputs are registered; every output reflects the state entered on the same clock edge.
REQ-022 IDLE, start edge -> RUN: cnt_enable = 1 from the cycle after the edge cycle.
REQ-023 IDLE, mode edge -> cnt_forward inverts; mode edges are ignored in RUN, PAUSE and ALARM.
REQ-024 RUN, stop edge -> PAUSE: cnt_enable = 0 on the next cycle; blink = 0 on PAUSE entry.
REQ-025 PAUSE, start edge -> RUN; counter values are untouched.
REQ-026 RUN, cnt_finish = 1 -> ALARM.
REQ-027 RUN, cnt_forward = 1, target_min != 0, cnt_minutes == target_min and cnt_seconds == 0 -> ALARM.
REQ-028 In ALARM: cnt_enable = 0 and alarm = 1; an internal 6-bit tick counter starts at 0 on ALARM entry and increments on each tick_1hz.
REQ-029 ALARM exits to IDLE on the tick at which the tick counter reaches ALARM_SECS-1; cnt_reset pulses for one cycle on entry to IDLE.
REQ-030 Clear edge in any state -> IDLE with one cnt_reset pulse; cnt_forward is retained.
REQ-031 Priority within one cycle: clear > finish/target > stop > start; if start and stop edges coincide in RUN, the result is PAUSE; in PAUSE the result is RUN.
REQ-032 Start edge while in ALARM is ignored; only clear or timeout leaves ALARM.
REQ-033 cnt_reset is never high for two consecutive cycles.

Reset
REQ-034 On reset: state = IDLE, cnt_enable = 0, cnt_forward = 1, cnt_reset = 1 for the reset cycle(s) then 0, alarm = 0, blink = 0, tick counter = 0.
REQ-035 All btn_prev registers reset to 1, so a button held through reset produces no edge.
REQ-036 Reset asserted mid-RUN or mid-ALARM takes effect on the next clk edge, overriding every other input.

Structure
REQ-037 State codes and the ALARM_SECS default are defined in the shared timer constants package/include and used by both the controller and the display logic.
REQ-038 One sub-module, edge_detect (a 1-bit registered rising-edge detector with reset value 1), is instantiated four times.

Verification
REQ-039 Reset, then start pulse at cycle 10 -> state = RUN and cnt_enable = 1 at cycle 11; stop pulse at cycle 20 -> cnt_enable = 0 at cycle 21, state = PAUSE.
REQ-040 target_min = 2, forward mode, cnt_minutes = 2 and cnt_seconds = 0 in RUN -> alarm = 1 next cycle; after 10 ticks -> state = IDLE with a single-cycle cnt_reset.
REQ-041 Mode edge in IDLE -> cnt_forward = 0; mode edge in RUN -> cnt_forward unchanged.
REQ-042 Clear and cnt_finish in the same RUN cycle -> IDLE with one cnt_reset pulse, alarm remains 0.
REQ-043 btn_start held high through reset release -> state stays IDLE until btn_start falls and rises again.
REQ-044 ALARM_SECS = 3, ALARM with 3 ticks -> blink toggles 0->1->0, then state = IDLE after the third tick.

Source files
------------

// File: rtl/timer_controller_pkg.sv
// Shared timer constants: FSM state codes and the default alarm duration,
// used by the controller and the display logic.
package timer_controller_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StAlarm = 2'd3
  } state_e;

  localparam int unsigned AlarmSecsDefault = 10;

endpackage

// File: rtl/timer_controller_edge_detect.sv
// Registered rising-edge detector. The history flop resets to 1 so that a
// level already high when reset is released is not reported as an edge.
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic prev_d, prev_q;

  always_comb begin
    prev_d = d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/timer_controller.sv
// Stopwatch/timer control FSM: turns button edges, the 1 Hz tick and counter
// feedback into registered enable/direction/clear controls plus alarm/blink.
module timer_controller
  import timer_controller_pkg::*;
#(
  parameter int unsigned ALARM_SECS = AlarmSecsDefault
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_clear,
  input  logic       btn_mode,
  input  logic [5:0] target_min,
  input  logic [5:0] cnt_seconds,
  input  logic [5:0] cnt_minutes,
  input  logic       cnt_finish,
  output logic       cnt_enable,
  output logic       cnt_forward,
  output logic       cnt_reset,
  output logic       alarm,
  output logic       blink,
  output logic [1:0] state
);

  localparam logic [5:0] TickLast = 6'(ALARM_SECS - 1);

  logic start_rise, stop_rise, clear_rise, mode_rise;

  edge_detect u_edge_start (.clk(clk), .reset(reset), .d(btn_start), .rise(start_rise));
  edge_detect u_edge_stop  (.clk(clk), .reset(reset), .d(btn_stop),  .rise(stop_rise));
  edge_detect u_edge_clear (.clk(clk), .reset(reset), .d(btn_clear), .rise(clear_rise));
  edge_detect u_edge_mode  (.clk(clk), .reset(reset), .d(btn_mode),  .rise(mode_rise));

  state_e     state_q, state_d;
  logic [5:0] tick_cnt_q, tick_cnt_d;
  logic       cnt_enable_q, cnt_enable_d;
  logic       cnt_forward_q, cnt_forward_d;
  logic       cnt_reset_q, cnt_reset_d;
  logic       alarm_q, alarm_d;
  logic       blink_q, blink_d;
  logic       target_hit;

  assign target_hit = cnt_forward_q && (target_min != 6'd0) &&
                      (cnt_minutes == target_min) && (cnt_seconds == 6'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      tick_cnt_q    <= 6'd0;
      cnt_enable_q  <= 1'b0;
      cnt_forward_q <= 1'b1;
      cnt_reset_q   <= 1'b1;
      alarm_q       <= 1'b0;
      blink_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      tick_cnt_q    <= tick_cnt_d;
      cnt_enable_q  <= cnt_enable_d;
      cnt_forward_q <= cnt_forward_d;
      cnt_reset_q   <= cnt_reset_d;
      alarm_q       <= alarm_d;
      blink_q       <= blink_d;
    end
  end

  // Priority: clear > finish/target > stop > start.
  always_comb begin
    state_d       = state_q;
    cnt_forward_d = cnt_forward_q;
    unique case (state_q)
      StIdle: begin
        if (start_rise) state_d = StRun;
        if (mode_rise)  cnt_forward_d = ~cnt_forward_q;
      end
      StRun: begin
        if (cnt_finish || target_hit) state_d = StAlarm;
        else if (stop_rise)           state_d = StPause;
      end
      StPause: begin
        if (start_rise) state_d = StRun;
      end
      StAlarm: begin
        if (tick_1hz && (tick_cnt_q == TickLast)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (clear_rise) state_d = StIdle;
  end

  always_comb begin
    logic entered;
    logic blinking;
    entered      = (state_d != state_q);
    blinking     = (state_d == StPause) || (state_d == StAlarm);
    cnt_enable_d = (state_d == StRun);
    alarm_d      = (state_d == StAlarm);
    // Guard keeps the clear pulse single-cycle even if clear follows a timeout.
    cnt_reset_d  = (state_d == StIdle) && (entered || clear_rise) && !cnt_reset_q;

    if (!blinking || entered) begin
      blink_d = 1'b0;
    end else if (tick_1hz) begin
      blink_d = ~blink_q;
    end else begin
      blink_d = blink_q;
    end

    if (state_d == StAlarm && state_q != StAlarm) begin
      tick_cnt_d = 6'd0;
    end else if (state_q == StAlarm && tick_1hz) begin
      tick_cnt_d = tick_cnt_q + 6'd1;
    end else begin
      tick_cnt_d = tick_cnt_q;
    end
  end

  assign cnt_enable  = cnt_enable_q;
  assign cnt_forward = cnt_forward_q;
  assign cnt_reset   = cnt_reset_q;
  assign alarm       = alarm_q;
  assign blink       = blink_q;
  assign state       = state_q;

endmodule

// File: tb/tb_timer_controller.sv
// Scoreboard bench for timer_controller: two instances (ALARM_SECS 10 and 3)
// share stimulus; expected output vectors are queued and checked per cycle.
module tb_timer_controller;

  localparam logic [1:0] SI = 2'd0, SR = 2'd1, SP = 2'd2, SA = 2'd3;

  logic       clk = 1'b0;
  logic       reset, tick_1hz, btn_start, btn_stop, btn_clear, btn_mode, cnt_finish;
  logic [5:0] target_min, cnt_seconds, cnt_minutes;

  logic       en_a, fwd_a, rst_a, al_a, bl_a;
  logic [1:0] st_a;
  logic       en_b, fwd_b, rst_b, al_b, bl_b;
  logic [1:0] st_b;

  always #5 clk = ~clk;

  timer_controller #(.ALARM_SECS(10)) u_dut_a (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .btn_start(btn_start),
    .btn_stop(btn_stop), .btn_clear(btn_clear), .btn_mode(btn_mode),
    .target_min(target_min), .cnt_seconds(cnt_seconds), .cnt_minutes(cnt_minutes),
    .cnt_finish(cnt_finish), .cnt_enable(en_a), .cnt_forward(fwd_a), .cnt_reset(rst_a),
    .alarm(al_a), .blink(bl_a), .state(st_a)
  );

  timer_controller #(.ALARM_SECS(3)) u_dut_b (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .btn_start(btn_start),
    .btn_stop(btn_stop), .btn_clear(btn_clear), .btn_mode(btn_mode),
    .target_min(target_min), .cnt_seconds(cnt_seconds), .cnt_minutes(cnt_minutes),
    .cnt_finish(cnt_finish), .cnt_enable(en_b), .cnt_forward(fwd_b), .cnt_reset(rst_b),
    .alarm(al_b), .blink(bl_b), .state(st_b)
  );

  typedef struct {
    int         cyc;
    bit         dut;
    logic [6:0] v;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Vector layout: {state[1:0], cnt_enable, cnt_forward, cnt_reset, alarm, blink}
  function automatic logic [6:0] ov(logic [1:0] st, logic en, logic fwd, logic rst,
                                    logic al, logic bl);
    return {st, en, fwd, rst, al, bl};
  endfunction

  // Expected output after i ticks in ALARM (after = cycle following the tick).
  function automatic logic [6:0] alarm_exp(int secs, int i, bit after);
    if (i < secs) return ov(SA, 1'b0, 1'b1, 1'b0, 1'b1, 1'(i % 2));
    if (i == secs && !after) return ov(SI, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    return ov(SI, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic exp1(input bit dut, input int d, input logic [6:0] v, input string nm);
    exp_t e;
    e.cyc = cyc + d; e.dut = dut; e.v = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic exp2(input int d, input logic [6:0] v, input string nm);
    exp1(1'b0, d, v, nm);
    exp1(1'b1, d, v, nm);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  exp_t       mon_e;
  logic [6:0] mon_act;
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e   = sb.pop_front();
      mon_act = mon_e.dut ? {st_b, en_b, fwd_b, rst_b, al_b, bl_b}
                          : {st_a, en_a, fwd_a, rst_a, al_a, bl_a};
      n_cmp++;
      if (mon_e.cyc != cyc || mon_act !== mon_e.v) begin
        n_err++;
        $display("FAIL %s: dut%0d cyc %0d (due %0d) got %b want %b",
                 mon_e.name, mon_e.dut, cyc, mon_e.cyc, mon_act, mon_e.v);
      end
    end
  end

  localparam logic [6:0] VRst  = {SI, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic [6:0] VIdle = {SI, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic [6:0] VRun  = {SR, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    reset = 1'b1; tick_1hz = 1'b0; btn_start = 1'b0; btn_stop = 1'b0;
    btn_clear = 1'b0; btn_mode = 1'b0; cnt_finish = 1'b0;
    target_min = 6'd0; cnt_seconds = 6'd0; cnt_minutes = 6'd0;

    exp2(1, VRst, "reset"); step();
    exp2(1, VRst, "reset_hold"); step();
    reset = 1'b0;
    exp2(1, VIdle, "reset_release"); step();
    repeat (3) step();

    btn_start = 1'b1; exp2(1, VRun, "start"); step();
    btn_start = 1'b0; exp2(1, VRun, "run_hold"); step();
    repeat (3) step();
    btn_mode = 1'b1; exp2(1, VRun, "mode_in_run"); step();
    btn_mode = 1'b0; step();
    btn_stop = 1'b1; exp2(1, ov(SP, 0, 1, 0, 0, 0), "stop"); step();
    btn_stop = 1'b0; step();
    tick_1hz = 1'b1; exp2(1, ov(SP, 0, 1, 0, 0, 1), "pause_tick"); step();
    tick_1hz = 1'b0; step();
    btn_start = 1'b1; btn_stop = 1'b1; exp2(1, VRun, "pause_start_stop"); step();
    btn_start = 1'b0; btn_stop = 1'b0; step();
    btn_start = 1'b1; btn_stop = 1'b1; exp2(1, ov(SP, 0, 1, 0, 0, 0), "run_start_stop"); step();
    btn_start = 1'b0; btn_stop = 1'b0; step();
    btn_start = 1'b1; exp2(1, VRun, "resume"); step();
    btn_start = 1'b0; step();

    target_min = 6'd0; exp2(1, VRun, "target_zero"); step();
    target_min = 6'd2; cnt_minutes = 6'd2; cnt_seconds = 6'd1;
    exp2(1, VRun, "target_secs_nonzero"); step();
    cnt_seconds = 6'd0; exp2(1, ov(SA, 0, 1, 0, 1, 0), "target_hit"); step();
    target_min = 6'd0; cnt_minutes = 6'd0;
    btn_start = 1'b1; exp2(1, ov(SA, 0, 1, 0, 1, 0), "start_in_alarm"); step();
    btn_start = 1'b0; step();

    for (int i = 1; i <= 10; i++) begin
      tick_1hz = 1'b1;
      exp1(1'b0, 1, alarm_exp(10, i, 1'b0), "alarm_tick");
      exp1(1'b1, 1, alarm_exp(3, i, 1'b0), "alarm_tick");
      step();
      tick_1hz = 1'b0;
      exp1(1'b0, 1, alarm_exp(10, i, 1'b1), "alarm_after_tick");
      exp1(1'b1, 1, alarm_exp(3, i, 1'b1), "alarm_after_tick");
      step();
    end

    btn_mode = 1'b1; exp2(1, ov(SI, 0, 0, 0, 0, 0), "mode_in_idle"); step();
    btn_mode = 1'b0; step();
    btn_start = 1'b1; exp2(1, ov(SR, 1, 0, 0, 0, 0), "start_down"); step();
    btn_start = 1'b0; step();
    target_min = 6'd2; cnt_minutes = 6'd2; cnt_seconds = 6'd0;
    exp2(1, ov(SR, 1, 0, 0, 0, 0), "target_down_ignored"); step();
    target_min = 6'd0; cnt_minutes = 6'd0;
    btn_clear = 1'b1; cnt_finish = 1'b1;
    exp2(1, ov(SI, 0, 0, 1, 0, 0), "clear_and_finish"); step();
    btn_clear = 1'b0; cnt_finish = 1'b0;
    exp2(1, ov(SI, 0, 0, 0, 0, 0), "clear_pulse_end"); step();
    step();
    btn_clear = 1'b1; exp2(1, ov(SI, 0, 0, 1, 0, 0), "clear_in_idle"); step();
    btn_clear = 1'b0; step();
    btn_start = 1'b1; exp2(1, ov(SR, 1, 0, 0, 0, 0), "start_down2"); step();
    btn_start = 1'b0; step();
    cnt_finish = 1'b1; exp2(1, ov(SA, 0, 0, 0, 1, 0), "finish"); step();
    cnt_finish = 1'b0; btn_clear = 1'b1;
    exp2(1, ov(SI, 0, 0, 1, 0, 0), "clear_alarm"); step();
    btn_clear = 1'b0; step();
    btn_mode = 1'b1; exp2(1, VIdle, "mode_back_up"); step();
    btn_mode = 1'b0; step();

    btn_start = 1'b1; exp2(1, VRun, "start_before_reset"); step();
    reset = 1'b1; exp2(1, VRst, "reset_mid_run"); step();
    reset = 1'b0; exp2(1, VIdle, "held_start_no_edge"); step();
    exp2(1, VIdle, "held_start_still_idle"); step();
    btn_start = 1'b0; step();
    btn_start = 1'b1; exp2(1, VRun, "start_after_release"); step();
    btn_start = 1'b0; step();
    cnt_finish = 1'b1; exp2(1, ov(SA, 0, 1, 0, 1, 0), "finish_up"); step();
    cnt_finish = 1'b0; reset = 1'b1; tick_1hz = 1'b1; btn_clear = 1'b1;
    exp2(1, VRst, "reset_mid_alarm"); step();
    reset = 1'b0; tick_1hz = 1'b0; btn_clear = 1'b0;
    exp2(1, VIdle, "after_alarm_reset"); step();

    for (int k = 0; k < 10 && sb.size() > 0; k++) step();
    if (sb.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
